// File: rtl/ttl_sync_counter.sv
// ttl_sync_counter: parametrised synchronous presettable counter (74LS160/161/163
// family, 74LS191-style up/down when UPDOWN=1) with chip-style ENP/ENT enables
// and a combinational ripple carry for cascading.
//
// Optional build macro: TTL_SYNC_COUNTER_OVF_EN
//   defined   -> _OVF is a registered sticky wrap flag (set on a counting edge
//                with _RCO=1, cleared by reset or load)
//   undefined -> _OVF is tied low and no flag register exists
module ttl_sync_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16,
   parameter int UPDOWN  = 0
) (
   input  logic             _CLK,
   input  logic             _RST,
   input  logic             _LD_N,
   input  logic             _ENP,
   input  logic             _ENT,
   input  logic             _UD,
   input  logic [WIDTH-1:0] _D,
   output logic [WIDTH-1:0] _Q,
   output logic             _RCO,
   output logic             _OVF
);

   // Refuse to build a part whose terminal count cannot be represented.
   if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("ttl_sync_counter: WIDTH=%0d outside 1..16", WIDTH);
   end
   if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("ttl_sync_counter: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
   end
   if (UPDOWN != 0 && UPDOWN != 1) begin : g_bad_updown
      $error("ttl_sync_counter: UPDOWN=%0d must be 0 or 1", UPDOWN);
   end

   // Top of the count. When MODULUS == 2**WIDTH this is all ones, so the
   // explicit wrap to zero coincides with natural binary overflow.
   localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

   logic             count_up;
   logic             count_en;
   logic             at_top;
   logic             at_zero;
   logic [WIDTH-1:0] q_next;

   // Up-only parts ignore _UD; it is still referenced so the pin stays wired.
   assign count_up = (UPDOWN == 0) ? 1'b1 : _UD;
   assign count_en = _LD_N & _ENP & _ENT;
   assign at_top   = (_Q == TERM);
   assign at_zero  = (_Q == '0);

   // Ripple carry is independent of _ENP so stages chain _RCO -> next _ENT.
   assign _RCO = _ENT & (count_up ? at_top : at_zero);

   // Next count value. Out-of-range values (loaded above TERM) never match
   // at_top, so they climb with natural 2**WIDTH wrap; down-count just decrements.
   always_comb begin
      q_next = _Q;
      if (count_up) begin
         q_next = at_top ? '0 : _Q + 1'b1;
      end else begin
         q_next = at_zero ? TERM : _Q - 1'b1;
      end
   end

   // Counter register: reset > load > count > hold.
   always_ff @(posedge _CLK) begin
      if (_RST) begin
         _Q <= '0;
      end else if (!_LD_N) begin
         _Q <= _D;
      end else if (count_en) begin
         _Q <= q_next;
      end
   end

`ifdef TTL_SYNC_COUNTER_OVF_EN
   logic ovf_q;

   // Sticky wrap flag; load clears it and, having priority, can never race a wrap.
   always_ff @(posedge _CLK) begin
      if (_RST) begin
         ovf_q <= 1'b0;
      end else if (!_LD_N) begin
         ovf_q <= 1'b0;
      end else if (count_en && _RCO) begin
         ovf_q <= 1'b1;
      end
   end

   assign _OVF = ovf_q;
`else
   assign _OVF = 1'b0;
`endif

endmodule
